// File: rtl/sm4_pkg.sv
// sm4_pkg: shared constants and FSM state encoding for the SM4 UART
// sequencer.
package sm4_pkg;

    localparam int BLOCK_BYTES  = 16;
    localparam int CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        START,
        WAIT,
        SEND,
        SEND_WAIT
    } state_t;

endpackage

// File: rtl/sm4_frame_timer.sv
// sm4_frame_timer: loadable up-counter with clear.
// o_expire flags LIMIT-1, and the count saturates there.
module sm4_frame_timer
    import sm4_pkg::*;
#(
    parameter int LIMIT = 1_041_600,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;
    logic         w_expire;

    assign w_expire = (r_cnt == W'(LIMIT - 1));
    assign o_expire = w_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && !w_expire) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/sm4_uart_ctrl.sv
// sm4_uart_ctrl: collects 16 UART bytes into an SM4 block, runs the
// core once, then streams the 16 result bytes back out, MSB first.
module sm4_uart_ctrl
    import sm4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_041_600,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    input  logic             i_tx_busy,
    output logic [127:0]     o_sm4_din,
    output logic             o_sm4_start,
    input  logic             i_sm4_done,
    input  logic [127:0]     i_sm4_dout,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic             o_overrun,
    output logic [CNT_W-1:0] o_blk_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [127:0]     r_in_buf;
    logic [127:0]     r_out_buf;
    logic [4:0]       r_byte_cnt;
    logic             r_guard;
    logic [7:0]       r_tx_data;
    logic             r_tx_start;
    logic             r_sm4_start;
    logic             r_frame_err;
    logic             r_overrun;
    logic [CNT_W-1:0] r_blk_cnt;

    logic       w_store;
    logic       w_tmo;
    logic       w_capture;
    logic       w_tx_go;
    logic       w_tx_ack;
    logic       w_ovr;
    logic       w_last;
    logic       w_expire;
    logic [3:0] w_idx;

    assign w_last = (r_byte_cnt == 5'(BLOCK_BYTES - 1));
    assign w_idx  = (r_state == IDLE) ? 4'd0 : r_byte_cnt[3:0];

    sm4_frame_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_store || (r_state != RECV)),
        .i_en       (r_state == RECV),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_tmo       = 1'b0;
        w_capture   = 1'b0;
        w_tx_go     = 1'b0;
        w_tx_ack    = 1'b0;
        w_ovr       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_rx_valid) begin
                    w_store     = 1'b1;
                    w_state_nxt = RECV;
                end
            end
            RECV: begin
                // A byte arriving on the expiry cycle keeps the frame alive.
                if (i_rx_valid) begin
                    w_store = 1'b1;
                    if (w_last) w_state_nxt = START;
                end else if (w_expire) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                w_ovr       = i_rx_valid;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_ovr = i_rx_valid;
                if (i_sm4_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_ovr = i_rx_valid;
                if (!i_tx_busy) begin
                    w_tx_go     = 1'b1;
                    w_state_nxt = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                // The guard cycle covers a transmitter whose busy flag lags.
                w_ovr = i_rx_valid;
                if (!r_guard && !i_tx_busy) begin
                    w_tx_ack    = 1'b1;
                    w_state_nxt = w_last ? IDLE : SEND;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_buf    <= '0;
            r_out_buf   <= '0;
            r_byte_cnt  <= '0;
            r_guard     <= 1'b0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_sm4_start <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_blk_cnt   <= '0;
        end else begin
            r_tx_start  <= w_tx_go;
            r_sm4_start <= w_store && (r_state == RECV) && w_last;
            r_frame_err <= w_tmo;
            r_overrun   <= w_ovr;
            r_guard     <= w_tx_go;

            if (w_store) begin
                r_in_buf[{~w_idx, 3'b000} +: 8] <= i_rx_data;
                r_byte_cnt <= (r_state == IDLE) ? 5'd1 : r_byte_cnt + 5'd1;
            end else if (w_tmo || w_capture) begin
                r_byte_cnt <= '0;
            end else if (w_tx_ack) begin
                r_byte_cnt <= w_last ? 5'd0 : r_byte_cnt + 5'd1;
            end

            if (w_capture) begin
                r_out_buf <= i_sm4_dout;
            end else if (w_tx_go) begin
                r_tx_data <= r_out_buf[127:120];
                r_out_buf <= {r_out_buf[119:0], 8'h00};
            end

            if (w_tx_ack && w_last) begin
                r_blk_cnt <= r_blk_cnt + CNT_W'(1);
            end
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_tx_start  = r_tx_start;
    assign o_sm4_din   = r_in_buf;
    assign o_sm4_start = r_sm4_start;
    assign o_busy      = (r_state != IDLE);
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_blk_cnt   = r_blk_cnt;

endmodule
